// File: rtl/cell_highlight_if.sv
// VGA pixel-stream bundle: timing counters, sync/blank strobes and RGB444 colour.
interface cell_highlight_if;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;

    modport master (output hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
    modport slave  (input  hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
endinterface

// File: rtl/cell_highlight.sv
// Draws a blinking border around the selected board cell; selection is frame-latched,
// and the pixel stream passes through a fixed 2-stage pipeline.
module cell_highlight #(
    parameter int          BOARD_X      = 100,
    parameter int          BOARD_Y      = 200,
    parameter int          CELL_SHIFT   = 5,
    parameter int          GRID_CELLS   = 10,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] HL_COLOR     = 12'hF00
) (
    input  logic                    clk,
    input  logic                    rst,
    cell_highlight_if.slave         vga_in,
    cell_highlight_if.master        vga_out,
    input  logic [7:0]              sel_cor,
    output logic                    sel_active
);
    typedef struct packed {
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_t;

    localparam logic [7:0]             SEL_NONE = 8'hFF;
    localparam logic [4:0]             GRID_N   = 5'(GRID_CELLS);
    localparam logic [7:0]             BLINK_M1 = 8'(BLINK_FRAMES - 1);
    localparam logic signed [11:0]     BX       = 12'(BOARD_X);
    localparam logic signed [11:0]     BY       = 12'(BOARD_Y);
    localparam logic signed [11:0]     SPAN     = 12'(GRID_CELLS << CELL_SHIFT);
    localparam logic [CELL_SHIFT-1:0]  EDGE_HI  = '1;

    // ---------------- frame-rate control ----------------
    logic       vblnk_prev;
    logic       frame_stb;
    logic [7:0] sel_q, sel_next;
    logic [7:0] blink_cnt;
    logic       blink_on;

    assign frame_stb = vga_in.vblnk & ~vblnk_prev;

    always_comb begin
        sel_next = SEL_NONE;
        if ({1'b0, sel_cor[7:4]} < GRID_N && {1'b0, sel_cor[3:0]} < GRID_N)
            sel_next = sel_cor;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev <= 1'b0;
            sel_q      <= SEL_NONE;
            sel_active <= 1'b0;
            blink_cnt  <= 8'd0;
            blink_on   <= 1'b1;
        end else begin
            vblnk_prev <= vga_in.vblnk;
            if (frame_stb) begin
                sel_q      <= sel_next;
                sel_active <= (sel_next != SEL_NONE);
                // A fresh selection restarts the blink phase so it shows at once.
                if (sel_next != sel_q) begin
                    blink_cnt <= 8'd0;
                    blink_on  <= 1'b1;
                end else if (blink_cnt == BLINK_M1) begin
                    blink_cnt <= 8'd0;
                    blink_on  <= ~blink_on;
                end else begin
                    blink_cnt <= blink_cnt + 8'd1;
                end
            end
        end
    end

    // ---------------- stage 1: geometry ----------------
    logic signed [11:0]    dx, dy;
    logic [3:0]            col, row;
    logic [CELL_SHIFT-1:0] dx_lo, dy_lo;
    logic                  in_board, border, match;
    vga_t                  pix_in, s1, s2;
    logic                  s1_match;

    always_comb begin
        pix_in   = '{vga_in.hcount, vga_in.hsync, vga_in.hblnk,
                     vga_in.vcount, vga_in.vsync, vga_in.vblnk, vga_in.rgb};
        dx       = $signed({1'b0, vga_in.hcount}) - BX;
        dy       = $signed({1'b0, vga_in.vcount}) - BY;
        in_board = !dx[11] && !dy[11] && (dx < SPAN) && (dy < SPAN);
        col      = dx[CELL_SHIFT+3:CELL_SHIFT];
        row      = dy[CELL_SHIFT+3:CELL_SHIFT];
        dx_lo    = dx[CELL_SHIFT-1:0];
        dy_lo    = dy[CELL_SHIFT-1:0];
        border   = (dx_lo == '0) || (dx_lo == EDGE_HI) ||
                   (dy_lo == '0) || (dy_lo == EDGE_HI);
        match    = in_board && border && ({col, row} == sel_q) && (sel_q != SEL_NONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= '0;
            s1_match <= 1'b0;
        end else begin
            s1       <= pix_in;
            s1_match <= match;
        end
    end

    // ---------------- stage 2: overlay ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s2 <= '0;
        end else begin
            s2     <= s1;
            s2.rgb <= (s1_match && blink_on && !s1.hblnk && !s1.vblnk) ? HL_COLOR : s1.rgb;
        end
    end

    assign vga_out.hcount = s2.hcount;
    assign vga_out.hsync  = s2.hsync;
    assign vga_out.hblnk  = s2.hblnk;
    assign vga_out.vcount = s2.vcount;
    assign vga_out.vsync  = s2.vsync;
    assign vga_out.vblnk  = s2.vblnk;
    assign vga_out.rgb    = s2.rgb;
endmodule
